// File: rtl/extract_scheduler_if.sv
// Stream bundle around extract_scheduler: PORTS buffer sources in, one muxed
// stream out to extract, plus the source-ID stream that tags each packet.
interface extract_scheduler_if #(
    parameter int PORTS          = 4,
    parameter int BUF_DATA_WIDTH = 256,
    parameter int BUF_KEEP_WIDTH = BUF_DATA_WIDTH / 8,
    parameter int ID_WIDTH       = (PORTS > 1) ? $clog2(PORTS) : 1
);
    logic [PORTS*BUF_DATA_WIDTH-1:0] s_inbuf_axis_tdata;
    logic [PORTS*BUF_KEEP_WIDTH-1:0] s_inbuf_axis_tkeep;
    logic [PORTS-1:0]                s_inbuf_axis_tvalid;
    logic [PORTS-1:0]                s_inbuf_axis_tready;
    logic [PORTS-1:0]                s_inbuf_axis_tlast;

    logic [BUF_DATA_WIDTH-1:0]       m_outbuf_axis_tdata;
    logic [BUF_KEEP_WIDTH-1:0]       m_outbuf_axis_tkeep;
    logic                            m_outbuf_axis_tvalid;
    logic                            m_outbuf_axis_tready;
    logic                            m_outbuf_axis_tlast;

    logic [ID_WIDTH-1:0]             m_id_axis_tdata;
    logic                            m_id_axis_tvalid;
    logic                            m_id_axis_tready;

    // Scheduler side.
    modport master (
        input  s_inbuf_axis_tdata, s_inbuf_axis_tkeep, s_inbuf_axis_tvalid, s_inbuf_axis_tlast,
        output s_inbuf_axis_tready,
        output m_outbuf_axis_tdata, m_outbuf_axis_tkeep, m_outbuf_axis_tvalid, m_outbuf_axis_tlast,
        input  m_outbuf_axis_tready,
        output m_id_axis_tdata, m_id_axis_tvalid,
        input  m_id_axis_tready
    );

    // Environment side: sources, extract and the ID consumer.
    modport slave (
        output s_inbuf_axis_tdata, s_inbuf_axis_tkeep, s_inbuf_axis_tvalid, s_inbuf_axis_tlast,
        input  s_inbuf_axis_tready,
        input  m_outbuf_axis_tdata, m_outbuf_axis_tkeep, m_outbuf_axis_tvalid, m_outbuf_axis_tlast,
        output m_outbuf_axis_tready,
        input  m_id_axis_tdata, m_id_axis_tvalid,
        output m_id_axis_tready
    );
endinterface

// File: rtl/extract_scheduler.sv
// Packet-level round-robin arbiter feeding one extract datapath; the source
// index of every granted packet is queued so downstream can tag its output.
module extract_scheduler #(
    parameter int PORTS          = 4,
    parameter int BUF_DATA_WIDTH = 256,
    parameter int BUF_KEEP_WIDTH = BUF_DATA_WIDTH / 8,
    parameter int ID_WIDTH       = (PORTS > 1) ? $clog2(PORTS) : 1,
    parameter int ID_FIFO_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    extract_scheduler_if.master  bus
);
    localparam int PTR_W = $clog2(ID_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state, state_nxt;
    logic [ID_WIDTH-1:0] grant, grant_nxt, last_grant, pick;
    logic                first;
    logic [1:0]          rst_sync;
    logic                rst_int_n;

    logic [ID_WIDTH-1:0] mem [ID_FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count;

    logic src_valid, src_last, gate, out_valid, hs, push, pop, id_full;

    // Assertion reaches every flop at once; release is retimed to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    assign src_valid = bus.s_inbuf_axis_tvalid[grant];
    assign src_last  = bus.s_inbuf_axis_tlast[grant];
    assign id_full   = (count == CNT_W'(ID_FIFO_DEPTH));
    assign gate      = !first || !id_full;
    assign out_valid = (state == GRANT) && src_valid && gate;
    assign hs        = out_valid && bus.m_outbuf_axis_tready;
    assign push      = hs && first;
    assign pop       = bus.m_id_axis_tvalid && bus.m_id_axis_tready;

    always_comb begin
        logic found;
        logic [ID_WIDTH-1:0] cand;
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        pick  = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= PORTS; i++) begin
            cand = ID_WIDTH'((int'(last_grant) + i) % PORTS);
            if (!found && bus.s_inbuf_axis_tvalid[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        case (state)
            IDLE: if (|bus.s_inbuf_axis_tvalid) begin
                grant_nxt = pick;
                state_nxt = GRANT;
            end
            GRANT: if (hs && src_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.s_inbuf_axis_tready  = '0;
        bus.m_outbuf_axis_tvalid = 1'b0;
        bus.m_outbuf_axis_tlast  = 1'b0;
        bus.m_outbuf_axis_tdata  = '0;
        bus.m_outbuf_axis_tkeep  = '0;
        if (state == GRANT) begin
            bus.m_outbuf_axis_tvalid       = out_valid;
            bus.m_outbuf_axis_tlast        = src_last;
            bus.m_outbuf_axis_tdata        = bus.s_inbuf_axis_tdata[int'(grant)*BUF_DATA_WIDTH +: BUF_DATA_WIDTH];
            bus.m_outbuf_axis_tkeep        = bus.s_inbuf_axis_tkeep[int'(grant)*BUF_KEEP_WIDTH +: BUF_KEEP_WIDTH];
            bus.s_inbuf_axis_tready[grant] = bus.m_outbuf_axis_tready && gate;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= ID_WIDTH'(PORTS - 1);
            first      <= 1'b1;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            if (hs) first <= src_last;
            if (hs && src_last) last_grant <= grant;
        end
    end

    // NOTE: the storage array has no reset; only pointers and count do, and the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= grant;
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign bus.m_id_axis_tvalid = (count != '0);
    assign bus.m_id_axis_tdata  = bus.m_id_axis_tvalid ? mem[rd_ptr] : '0;
endmodule
